bank_slot_master: RTL and testbench

- Hardware initiator for one bank_ram_subsystem slot; the RTL counterpart of the slot-driving bench tasks.
- Accepts a burst job (rw, mask, base address, row count), then issues one command per row on the slot command channel.
- Write jobs: forwards a source row stream to the slot write-data channel.
- Read jobs: collects in-order slot read data into an internal FIFO and presents it on a backpressured sink stream.

---
 rtl/bank_pkg.sv | 28 ++
 rtl/bank_slot_rd_fifo.sv | 56 +++++
 rtl/bank_slot_master.sv | 194 +++++++++++++++++++
 tb/tb_bank_slot_master.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bank_pkg.sv
// Shared types and helpers for the bank slot initiator: row layout, FSM states
// and the bank-mask function applied to returned read rows.
package bank_pkg;

    localparam int unsigned NUM_BANKS  = 5;
    localparam int unsigned ADDR_WIDTH = 9;
    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned ROW_WIDTH  = NUM_BANKS * DATA_WIDTH;

    typedef logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] row_t;

    typedef enum logic [2:0] {
        StIdle,
        StWrRun,
        StRdRun,
        StRdDrain,
        StDone
    } state_e;

    function automatic row_t mask_apply(input row_t row, input logic [NUM_BANKS-1:0] mask);
        row_t res;
        for (int b = 0; b < NUM_BANKS; b++) begin
            res[b] = mask[b] ? row[b] : '0;
        end
        return res;
    endfunction

endpackage

// File: rtl/bank_slot_rd_fifo.sv
// Synchronous read-return FIFO with occupancy count; a push is accepted at full
// only when a pop happens in the same cycle.
module bank_slot_rd_fifo #(
    parameter int unsigned WIDTH = 160,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_full;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!w_full || w_do_pop);
    assign o_data    = r_mem[r_rptr];
    assign o_count   = r_count;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

endmodule

// File: rtl/bank_slot_master.sv
// Burst initiator for one bank_ram_subsystem slot: issues one row command per
// cycle, streams write rows through and returns read rows via a credited FIFO.
module bank_slot_master
    import bank_pkg::*;
#(
    parameter int unsigned SLOT_FIFO_DEPTH = 4,
    parameter int unsigned RD_FIFO_DEPTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  job_valid,
    output logic                  job_ready,
    input  logic                  job_rw,
    input  logic [NUM_BANKS-1:0]  job_mask,
    input  logic [ADDR_WIDTH-1:0] job_base,
    input  logic [ADDR_WIDTH:0]   job_len,
    output logic                  job_done,
    input  logic                  src_valid,
    output logic                  src_ready,
    input  logic [ROW_WIDTH-1:0]  src_data,
    output logic                  snk_valid,
    input  logic                  snk_ready,
    output logic [ROW_WIDTH-1:0]  snk_data,
    output logic                  cmd_valid,
    output logic                  cmd_rw,
    output logic [NUM_BANKS-1:0]  cmd_mask,
    output logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic                  cmd_ready,
    output logic                  wvalid,
    output logic [ROW_WIDTH-1:0]  wdata,
    input  logic                  wready,
    input  logic                  rvalid,
    input  logic [ROW_WIDTH-1:0]  rdata
);

    localparam int unsigned LW = ADDR_WIDTH + 1;
    localparam int unsigned CW = ADDR_WIDTH + 2;
    localparam int unsigned FW = $clog2(RD_FIFO_DEPTH) + 1;
    localparam int unsigned SW = FW + 1;

    state_e                r_state;
    state_e                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [LW-1:0]         r_len;
    logic [LW-1:0]         r_cmd_cnt;
    logic [LW-1:0]         r_dat_cnt;
    logic [FW-1:0]         r_outstanding;
    logic                  r_cmd_valid;
    logic                  r_cmd_rw;
    logic [NUM_BANKS-1:0]  r_cmd_mask;
    logic [ADDR_WIDTH-1:0] r_cmd_addr;

    logic                  w_job_acc;
    logic                  w_job_empty;
    logic                  w_cmd_hs;
    logic                  w_dat_hs;
    logic                  w_wr_gate;
    logic                  w_r_acc;
    logic                  w_pop;
    logic                  w_empty;
    logic                  w_cmd_raise;
    logic                  w_cmd_valid_nxt;
    logic [LW-1:0]         w_cmd_cnt_nxt;
    logic [LW-1:0]         w_dat_cnt_nxt;
    logic [FW-1:0]         w_out_nxt;
    logic [FW-1:0]         w_fifo_cnt;
    logic [FW-1:0]         w_fifo_cnt_nxt;
    row_t                  w_push_row;
    row_t                  w_pop_row;

    assign job_ready   = (r_state == StIdle);
    assign job_done    = (r_state == StDone);
    assign w_job_acc   = job_valid && job_ready;
    assign w_job_empty = (job_mask == '0) || (job_len == '0);

    assign cmd_valid = r_cmd_valid;
    assign cmd_rw    = r_cmd_rw;
    assign cmd_mask  = r_cmd_mask;
    assign cmd_addr  = r_cmd_addr;
    assign w_cmd_hs  = r_cmd_valid && cmd_ready;

    // Data may run at most SLOT_FIFO_DEPTH rows ahead of its commands.
    assign w_wr_gate = (r_state == StWrRun) && (r_dat_cnt < r_len) &&
                       ({1'b0, r_dat_cnt} < {1'b0, r_cmd_cnt} + CW'(SLOT_FIFO_DEPTH));
    assign wvalid    = src_valid && w_wr_gate;
    assign src_ready = wready && w_wr_gate;
    assign wdata     = src_data;
    assign w_dat_hs  = src_valid && wready && w_wr_gate;

    assign w_r_acc    = rvalid && (r_outstanding != '0);
    assign w_push_row = mask_apply(rdata, r_cmd_mask);
    assign snk_valid  = !w_empty;
    assign snk_data   = w_pop_row;
    assign w_pop      = snk_valid && snk_ready;

    assign w_cmd_cnt_nxt  = r_cmd_cnt + LW'(w_cmd_hs);
    assign w_dat_cnt_nxt  = r_dat_cnt + LW'(w_dat_hs);
    assign w_out_nxt      = r_outstanding + FW'(w_cmd_hs && !r_cmd_rw) - FW'(w_r_acc);
    assign w_fifo_cnt_nxt = w_fifo_cnt + FW'(w_r_acc) - FW'(w_pop);

    bank_slot_rd_fifo #(
        .WIDTH (ROW_WIDTH),
        .DEPTH (RD_FIFO_DEPTH)
    ) u_rd_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_r_acc),
        .i_data  (w_push_row),
        .i_pop   (w_pop),
        .o_data  (w_pop_row),
        .o_empty (w_empty),
        .o_count (w_fifo_cnt)
    );

    // Next command is judged on post-edge counts so handshakes can go back to back.
    always_comb begin
        w_cmd_raise = 1'b0;
        if (r_state == StWrRun) begin
            w_cmd_raise = (w_cmd_cnt_nxt < r_len) &&
                          ({1'b0, w_cmd_cnt_nxt} < {1'b0, w_dat_cnt_nxt} + CW'(SLOT_FIFO_DEPTH));
        end else if (r_state == StRdRun) begin
            w_cmd_raise = (w_cmd_cnt_nxt < r_len) &&
                          ({1'b0, w_out_nxt} + {1'b0, w_fifo_cnt_nxt} < SW'(RD_FIFO_DEPTH));
        end
        w_cmd_valid_nxt = (r_cmd_valid && !cmd_ready) || w_cmd_raise ||
                          (w_job_acc && !w_job_empty);
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_job_acc) begin
                    w_state_nxt = w_job_empty ? StDone : (job_rw ? StWrRun : StRdRun);
                end
            end
            StWrRun: begin
                if (w_cmd_cnt_nxt == r_len && w_dat_cnt_nxt == r_len) begin
                    w_state_nxt = StDone;
                end
            end
            StRdRun: begin
                if (w_cmd_cnt_nxt == r_len) begin
                    w_state_nxt = StRdDrain;
                end
            end
            StRdDrain: begin
                if (r_outstanding == '0 && w_empty) begin
                    w_state_nxt = StDone;
                end
            end
            StDone:  w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= StIdle;
            r_base        <= '0;
            r_len         <= '0;
            r_cmd_cnt     <= '0;
            r_dat_cnt     <= '0;
            r_outstanding <= '0;
            r_cmd_valid   <= 1'b0;
            r_cmd_rw      <= 1'b0;
            r_cmd_mask    <= '0;
            r_cmd_addr    <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_cmd_valid   <= w_cmd_valid_nxt;
            r_outstanding <= w_out_nxt;
            if (w_job_acc) begin
                r_base     <= job_base;
                r_len      <= job_len;
                r_cmd_cnt  <= '0;
                r_dat_cnt  <= '0;
                r_cmd_rw   <= job_rw;
                r_cmd_mask <= job_mask;
                r_cmd_addr <= job_base;
            end else begin
                r_cmd_cnt <= w_cmd_cnt_nxt;
                r_dat_cnt <= w_dat_cnt_nxt;
                if (w_cmd_hs) begin
                    r_cmd_addr <= r_base + w_cmd_cnt_nxt[ADDR_WIDTH-1:0];
                end
            end
        end
    end

    // A read beat with nothing outstanding is a subsystem protocol error.
    assert property (@(posedge clk) disable iff (rst) (rvalid |-> (r_outstanding != '0)));

endmodule

// File: tb/tb_bank_slot_master.sv
// Directed bench for bank_slot_master with a 2-cycle-latency slot responder.
module tb_bank_slot_master;
    import bank_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  job_valid, job_ready, job_rw, job_done;
    logic [NUM_BANKS-1:0]  job_mask;
    logic [ADDR_WIDTH-1:0] job_base;
    logic [ADDR_WIDTH:0]   job_len;
    logic                  src_valid, src_ready, snk_valid, snk_ready;
    logic [ROW_WIDTH-1:0]  src_data, snk_data, wdata;
    logic                  cmd_valid, cmd_rw, cmd_ready, wvalid, wready;
    logic [NUM_BANKS-1:0]  cmd_mask;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic                  rvalid = 1'b0;
    logic [ROW_WIDTH-1:0]  rdata = '0;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int src_idx  = 0;
    int done_cnt = 0;

    logic [8:0]           cmd_adr[$];
    logic                 cmd_rwq[$];
    logic [4:0]           cmd_mq[$];
    int                   cmd_cyc[$];
    logic [ROW_WIDTH-1:0] wrows[$];
    logic [ROW_WIDTH-1:0] snk_rows[$];
    int                   snk_cyc[$];
    int                   done_cyc[$];
    int                   rd_due[$];
    logic [8:0]           rd_adr[$];

    bank_slot_master #(
        .SLOT_FIFO_DEPTH (4),
        .RD_FIFO_DEPTH   (8)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .job_valid (job_valid),
        .job_ready (job_ready),
        .job_rw    (job_rw),
        .job_mask  (job_mask),
        .job_base  (job_base),
        .job_len   (job_len),
        .job_done  (job_done),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .src_data  (src_data),
        .snk_valid (snk_valid),
        .snk_ready (snk_ready),
        .snk_data  (snk_data),
        .cmd_valid (cmd_valid),
        .cmd_rw    (cmd_rw),
        .cmd_mask  (cmd_mask),
        .cmd_addr  (cmd_addr),
        .cmd_ready (cmd_ready),
        .wvalid    (wvalid),
        .wdata     (wdata),
        .wready    (wready),
        .rvalid    (rvalid),
        .rdata     (rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic row_t wr_row(input int idx);
        row_t r;
        for (int b = 0; b < NUM_BANKS; b++) r[b] = 32'hA000_0000 | (32'(idx) << 8) | 32'(b);
        return r;
    endfunction

    function automatic row_t rd_row(input logic [8:0] a, input logic [4:0] m);
        row_t r;
        for (int b = 0; b < NUM_BANKS; b++)
            r[b] = m[b] ? (32'hD000_0000 | (32'(a) << 8) | 32'(b)) : 32'h0;
        return r;
    endfunction

    always @(posedge clk) begin
        if (job_valid && job_ready) src_idx <= 0;
        else if (src_valid && src_ready) src_idx <= src_idx + 1;
    end
    assign src_data = wr_row(src_idx);

    // Observe handshakes mid-cycle, then drive the slot read-return channel.
    always @(negedge clk) begin
        if (rst) begin
            rd_due.delete();
            rd_adr.delete();
            rvalid = 1'b0;
            rdata  = '0;
        end else begin
            if (cmd_valid && cmd_ready) begin
                cmd_adr.push_back(cmd_addr);
                cmd_rwq.push_back(cmd_rw);
                cmd_mq.push_back(cmd_mask);
                cmd_cyc.push_back(cyc);
                if (!cmd_rw) begin
                    rd_due.push_back(cyc + 2);
                    rd_adr.push_back(cmd_addr);
                end
            end
            if (wvalid && wready) wrows.push_back(wdata);
            if (snk_valid && snk_ready) begin
                snk_rows.push_back(snk_data);
                snk_cyc.push_back(cyc);
            end
            if (job_done) begin
                done_cnt++;
                done_cyc.push_back(cyc);
            end
            if (rd_due.size() > 0 && rd_due[0] == cyc) begin
                rvalid = 1'b1;
                rdata  = rd_row(rd_adr[0], 5'h1f);
                void'(rd_due.pop_front());
                void'(rd_adr.pop_front());
            end else begin
                rvalid = 1'b0;
                rdata  = '0;
            end
        end
    end

    task automatic check(input string tag, input logic [ROW_WIDTH-1:0] obs,
                         input logic [ROW_WIDTH-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        cmd_adr.delete(); cmd_rwq.delete(); cmd_mq.delete(); cmd_cyc.delete();
        wrows.delete(); snk_rows.delete(); snk_cyc.delete(); done_cyc.delete();
        done_cnt = 0;
    endtask

    task automatic start_job(input logic rw, input logic [4:0] m, input logic [8:0] b,
                             input logic [9:0] l, output int k);
        job_rw = rw; job_mask = m; job_base = b; job_len = l; job_valid = 1'b1;
        k = cyc;
        step(1);
        job_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        for (int i = 0; i < budget && done_cnt == 0; i++) step(1);
        check(tag, done_cnt, 1);
    endtask

    function automatic int first_done();
        return (done_cyc.size() > 0) ? done_cyc[0] : -1;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        rst = 1'b1; job_valid = 1'b0; job_rw = 1'b0; job_mask = '0; job_base = '0;
        job_len = '0; src_valid = 1'b1; snk_ready = 1'b0; cmd_ready = 1'b1; wready = 1'b1;
        #12;
        check("rst_job_ready", job_ready, 1);
        check("rst_cmd_valid", cmd_valid, 0);
        check("rst_cmd_fields", {cmd_rw, cmd_mask, cmd_addr}, 0);
        check("rst_wvalid", wvalid, 0);
        check("rst_src_ready", src_ready, 0);
        check("rst_snk_valid", snk_valid, 0);
        check("rst_job_done", job_done, 0);
        @(posedge clk); #1 rst = 1'b0;
        step(2);
        check("idle_src_ignored", src_ready, 0);

        // Write burst, everything ready
        clear_logs();
        start_job(1'b1, 5'h1f, 9'h010, 10'd4, k);
        wait_done(50, "wr_done_seen");
        step(3);
        check("wr_cmd_n", cmd_adr.size(), 4);
        check("wr_wdata_n", wrows.size(), 4);
        for (int i = 0; i < cmd_adr.size(); i++) begin
            check("wr_cmd_addr", cmd_adr[i], 32'h010 + i);
            check("wr_cmd_cyc", cmd_cyc[i], k + 1 + i);
            check("wr_cmd_rw_mask", {cmd_rwq[i], cmd_mq[i]}, 6'b1_11111);
        end
        for (int i = 0; i < wrows.size(); i++) check("wr_wdata", wrows[i], wr_row(i));
        check("wr_done_cyc", first_done(), k + 5);
        check("wr_done_once", done_cnt, 1);

        // Read burst with address wrap and partial mask
        clear_logs();
        snk_ready = 1'b1;
        start_job(1'b0, 5'b00101, 9'h1FE, 10'd4, k);
        wait_done(60, "rd_done_seen");
        step(3);
        check("rd_cmd_n", cmd_adr.size(), 4);
        for (int i = 0; i < cmd_adr.size(); i++) begin
            check("rd_cmd_addr", cmd_adr[i], (32'h1FE + i) % 512);
            check("rd_cmd_cyc", cmd_cyc[i], k + 1 + i);
            check("rd_cmd_rw_mask", {cmd_rwq[i], cmd_mq[i]}, 6'b0_00101);
        end
        check("rd_snk_n", snk_rows.size(), 4);
        for (int i = 0; i < snk_rows.size(); i++)
            check("rd_snk_data", snk_rows[i], rd_row(9'((32'h1FE + i) % 512), 5'b00101));
        check("rd_snk_lat", (snk_cyc.size() > 0) ? snk_cyc[0] : -1, k + 4);
        check("rd_done_once", done_cnt, 1);

        // Write skew bound with the data channel stalled
        clear_logs();
        wready = 1'b0;
        start_job(1'b1, 5'h1f, 9'h040, 10'd8, k);
        step(10);
        check("skew_cmd_n", cmd_adr.size(), 4);
        check("skew_cmd_held", cmd_valid, 0);
        check("skew_no_data", wrows.size(), 0);
        wready = 1'b1;
        wait_done(80, "skew_done_seen");
        step(3);
        check("skew_cmd_total", cmd_adr.size(), 8);
        check("skew_last_addr", (cmd_adr.size() == 8) ? cmd_adr[7] : 9'h0, 9'h047);
        check("skew_wdata_n", wrows.size(), 8);
        for (int i = 0; i < wrows.size(); i++) check("skew_wdata", wrows[i], wr_row(i));

        // Read credit with the sink stalled
        clear_logs();
        snk_ready = 1'b0;
        start_job(1'b0, 5'b11010, 9'h100, 10'd16, k);
        step(30);
        check("cred_cmd_n", cmd_adr.size(), 8);
        check("cred_snk_valid", snk_valid, 1);
        check("cred_no_snk", snk_rows.size(), 0);
        snk_ready = 1'b1;
        wait_done(200, "cred_done_seen");
        step(3);
        check("cred_cmd_total", cmd_adr.size(), 16);
        check("cred_snk_n", snk_rows.size(), 16);
        for (int i = 0; i < snk_rows.size(); i++)
            check("cred_snk_data", snk_rows[i], rd_row(9'(32'h100 + i), 5'b11010));
        check("cred_done_once", done_cnt, 1);

        // Degenerate jobs: mask=0 and len=0
        clear_logs();
        start_job(1'b1, 5'h00, 9'h000, 10'd5, k);
        step(4);
        check("m0_no_cmd", cmd_adr.size(), 0);
        check("m0_no_data", wrows.size(), 0);
        check("m0_done_cyc", first_done(), k + 1);
        check("m0_done_once", done_cnt, 1);
        clear_logs();
        start_job(1'b0, 5'h1f, 9'h000, 10'd0, k);
        step(4);
        check("l0_no_cmd", cmd_adr.size(), 0);
        check("l0_done_cyc", first_done(), k + 1);

        // Reset in the middle of a read job
        clear_logs();
        snk_ready = 1'b1;
        start_job(1'b0, 5'h1f, 9'h020, 10'd8, k);
        for (int i = 0; i < 60 && snk_rows.size() < 3; i++) step(1);
        check("mid_rows_before_rst", snk_rows.size(), 3);
        rst = 1'b1;
        #1;
        check("mid_rst_cmd_valid", cmd_valid, 0);
        check("mid_rst_cmd_fields", {cmd_rw, cmd_mask, cmd_addr}, 0);
        check("mid_rst_snk_valid", snk_valid, 0);
        check("mid_rst_job_ready", job_ready, 1);
        check("mid_rst_job_done", job_done, 0);
        check("mid_rst_src_ready", src_ready, 0);
        step(2);
        rst = 1'b0;
        step(2);
        clear_logs();
        start_job(1'b1, 5'b10000, 9'h1FF, 10'd2, k);
        wait_done(30, "post_done_seen");
        step(3);
        check("post_cmd_n", cmd_adr.size(), 2);
        check("post_addr0", (cmd_adr.size() > 0) ? cmd_adr[0] : 9'h0AA, 9'h1FF);
        check("post_addr1", (cmd_adr.size() > 1) ? cmd_adr[1] : 9'h0AA, 9'h000);
        check("post_done_cyc", first_done(), k + 3);
        check("post_wdata_n", wrows.size(), 2);
        for (int i = 0; i < wrows.size(); i++) check("post_wdata", wrows[i], wr_row(i));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
